fmul_norm_round: RTL and testbench
==================================

# fmul_norm_round

Final stage of the pipelined single-precision multiplier. Consumes the registered add/normalize bundle: the 48-bit significand product, biased exponent, rounding mode, sign and special-case flags. Normalizes the product, denormalizes on underflow and rounds per the MIPS rounding mode. Handles overflow, infinity and NaN, and registers the 32-bit IEEE-754 result with a valid bit.

## Interface
- No parameters.
- clk  in  1  pipeline clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- e  in  1  stage enable; 0 stalls the stage and holds all registers.
- n_valid  in  1  the input bundle is a live operation.
- n_z48  in  48  unsigned product of two 24-bit significands.
- n_inf_nan_frac  in  23  fraction to emit for NaN results.
- n_exp10  in  10  two's-complement biased exponent, computed as ea+eb-127.
- n_rm  in  2  rounding mode: 00 RN (nearest-even), 01 RZ, 10 RP (+inf), 11 RM (-inf).
- n_sign  in  1  result sign.
- n_is_nan  in  1  force NaN result.
- n_is_inf  in  1  force infinity result.
- s  out  32  IEEE single result.
- s_valid  out  1  s holds a completed operation.
- flags  out  3  {overflow, underflow, inexact}, sticky. Present only with FMUL_FLAGS_EN.
- flag_clr  in  1  synchronous clear of the sticky flags. Present only with FMUL_FLAGS_EN.

## Operation
- Normalize:
  - If z48[47]=1: shift right 1 and set exp=exp10+1.
  - Else: left-shift by the leading-zero count of z48[46:0] so that bit46 leads, limited so that exp stays ≥1; exp decreases by the shift amount.
  - If z48=0: the result is signed zero.
- Denormalize: if exp ≤ 0 after normalization, shift right by (1-exp), OR shifted-out bits into sticky, and set exp=0. Shifts of 26 or more collapse the significand to sticky only.
- Round:
  - Kept fraction is bits 45:23; guard is bit 22; sticky is the OR of bits 21:0 plus any denorm sticky.
  - RN rounds up when guard=1 and (sticky=1 or lsb=1).
  - RP rounds up when guard|sticky=1 and sign=0.
  - RM rounds up when guard|sticky=1 and sign=1.
  - RZ never rounds up.
  - A carry out of the fraction increments exp; this covers both denormal-to-normal and 1.111…→10.0.
- Overflow: if exp ≥ 255 after rounding:
  - The result is {sign, 8'hFF, 0} for RN, for RP with sign=0, and for RM with sign=1.
  - Otherwise the result is {sign, 8'hFE, 23'h7FFFFF}.
- Special-case priority: n_is_nan gives {1'b0, 8'hFF, n_inf_nan_frac}. Otherwise n_is_inf gives {sign, 8'hFF, 0}. Otherwise the computed result is used. Special cases raise no flags.
- Flags (FMUL_FLAGS_EN only):
  - inexact = guard|sticky, or overflow.
  - underflow = the result is tiny (exp=0 before rounding) and inexact.
  - overflow as defined above.
  - Flags are ORed into the sticky register only when e & n_valid.
  - flag_clr wins over a same-cycle set.

## Timing
- Latency is 1 cycle. The datapath is combinational from the n_* inputs to the output register.
- Registers update on the rising clk edge only when e=1:
  - s takes the computed result.
  - s_valid takes n_valid.
  - With e=0, s, s_valid and flags hold.
- When n_valid=0 and e=1: s still captures the computed value and s_valid=0. Consumers qualify on s_valid.
- Reset while clrn=0: s=0, s_valid=0, flags=0 immediately and asynchronously. An in-flight operation is discarded with no partial result.
- flag_clr acts regardless of e.

## Configuration
- FMUL_FLAGS_EN defined: flags and flag_clr ports exist, along with the sticky register and flag logic.
- FMUL_FLAGS_EN undefined: ports and logic are absent. s and s_valid behaviour is identical.

## Structure
- fpu_pkg holds:
  - rounding-mode localparams: RM_RN=2'b00, RM_RZ=2'b01, RM_RP=2'b10, RM_RM=2'b11;
  - constants FP_INF_EXP=8'hFF and FP_MAXFIN_FRAC=23'h7FFFFF;
  - flag bit indices.
- One sub-module: lzc48, a combinational leading-zero count over 47 bits producing a 6-bit count. Instantiated once.

## Test plan
- 1.5×1.5: z48=0x900000000000, exp10=127, RN, valid → next cycle s=0x40100000, s_valid=1, no flags.
- Tie rounding: z48=0x400000400000, exp10=127, sign=0.
  - RN → s=0x3F800000.
  - RP → s=0x3F800001.
  - Both set inexact.
- Overflow: z48=0x400000000000, exp10=300, sign=0.
  - RN → 0x7F800000.
  - RZ → 0x7F7FFFFF.
  - Both set overflow and inexact.
- Denormal: z48=0x400000000000, exp10=-10, RN → s=0x00001000. Exact, so no underflow flag.
- Specials:
  - is_nan=1, frac=0x400000 → 0x7FC00000.
  - is_inf=1, sign=1 → 0xFF800000.
- Stall/reset:
  - e=0 for 3 cycles with changing inputs → s and s_valid held.
  - Asserting clrn=0 mid-stall → all outputs 0 before the next edge.
  - flag_clr with a simultaneous overflow → flags=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants for the single-precision multiplier pipeline:
// rounding-mode encodings, IEEE field constants and sticky-flag bit positions.
package fpu_pkg;

  localparam logic [1:0] RM_RN = 2'b00;
  localparam logic [1:0] RM_RZ = 2'b01;
  localparam logic [1:0] RM_RP = 2'b10;
  localparam logic [1:0] RM_RM = 2'b11;

  localparam logic [7:0]  FP_INF_EXP     = 8'hFF;
  localparam logic [22:0] FP_MAXFIN_FRAC = 23'h7FFFFF;

  localparam int unsigned FLG_OVF = 2;
  localparam int unsigned FLG_UDF = 1;
  localparam int unsigned FLG_INX = 0;

endpackage

// File: rtl/fmul_norm_round_lzc48.sv
// Leading-zero count over a 47-bit significand; returns 47 for an all-zero input.
module lzc48 (
  input  logic [46:0] a_i,
  output logic [5:0]  cnt_o
);

  always_comb begin
    cnt_o = 6'd47;
    for (int unsigned i = 0; i < 47; i++) begin
      if (a_i[i]) cnt_o = 6'(46 - i);
    end
  end

endmodule

// File: rtl/fmul_norm_round.sv
// Final multiplier stage: normalize, denormalize, round, overflow/special handling.
// Optional sticky IEEE flags and flag_clr are built when FMUL_FLAGS_EN is defined.
module fmul_norm_round
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        e,
  input  logic        n_valid,
  input  logic [47:0] n_z48,
  input  logic [22:0] n_inf_nan_frac,
  input  logic [9:0]  n_exp10,
  input  logic [1:0]  n_rm,
  input  logic        n_sign,
  input  logic        n_is_nan,
  input  logic        n_is_inf,
`ifdef FMUL_FLAGS_EN
  output logic [2:0]  flags,
  input  logic        flag_clr,
`endif
  output logic [31:0] s,
  output logic        s_valid
);

  logic [5:0]         lz;
  logic [5:0]         shamt;
  logic signed [10:0] exp_in, exp_n, exp_d, exp_r, lim;
  logic [10:0]        dsh;
  logic [46:0]        sig_n, sig_d, mask;
  logic               dsticky, guard, sticky, inc, tiny, ovf, inexact, udf, no_flags;
  logic [24:0]        rnd;
  logic [31:0]        res;
  logic [2:0]         new_flags;
  logic [31:0]        s_d, s_q;
  logic               s_valid_q;

  lzc48 u_lzc (.a_i(n_z48[46:0]), .cnt_o(lz));

  always_comb begin
    exp_in  = {n_exp10[9], n_exp10};
    lim     = exp_in - 11'sd1;
    shamt   = '0;
    sig_n   = n_z48[46:0];
    exp_n   = exp_in;
    if (n_z48[47]) begin
      sig_n = n_z48[47:1];
      exp_n = exp_in + 11'sd1;
    end else begin
      if (lim <= 0)                      shamt = '0;
      else if (lim < $signed({5'b0, lz})) shamt = lim[5:0];
      else                               shamt = lz;
      sig_n = n_z48[46:0] << shamt;
      exp_n = exp_in - $signed({5'b0, shamt});
    end

    // Tiny results are kept at the minimum normal exponent with a zero hidden
    // bit; the encoded exponent is derived from the hidden bit after rounding.
    dsh     = 11'(11'sd1 - exp_n);
    mask    = '1;
    dsticky = 1'b0;
    sig_d   = sig_n;
    exp_d   = exp_n;
    if (exp_n <= 0) begin
      exp_d = 11'sd1;
      if (dsh >= 11'd26) begin
        sig_d   = '0;
        dsticky = |sig_n;
      end else begin
        mask    = ~(mask << dsh[4:0]);
        sig_d   = sig_n >> dsh[4:0];
        dsticky = |(sig_n & mask);
      end
    end

    tiny   = ~sig_d[46];
    guard  = sig_d[22];
    sticky = (|sig_d[21:0]) | dsticky;
    case (n_rm)
      RM_RN:   inc = guard & (sticky | sig_d[23]);
      RM_RZ:   inc = 1'b0;
      RM_RP:   inc = (guard | sticky) & ~n_sign;
      default: inc = (guard | sticky) & n_sign;
    endcase

    rnd = {1'b0, sig_d[46:23]} + 25'(inc);
    if (rnd[24])      exp_r = exp_d + 11'sd1;
    else if (rnd[23]) exp_r = exp_d;
    else              exp_r = '0;

    ovf     = (exp_r >= 11'sd255);
    inexact = guard | sticky | ovf;
    udf     = tiny & inexact;
    res     = {n_sign, exp_r[7:0], rnd[22:0]};
    if (ovf) begin
      if ((n_rm == RM_RN) || (n_rm == RM_RP && !n_sign) || (n_rm == RM_RM && n_sign))
        res = {n_sign, FP_INF_EXP, 23'b0};
      else
        res = {n_sign, 8'hFE, FP_MAXFIN_FRAC};
    end

    no_flags = 1'b0;
    if (n_z48 == '0) begin
      res      = {n_sign, 31'b0};
      no_flags = 1'b1;
    end
    if (n_is_nan) begin
      res      = {1'b0, FP_INF_EXP, n_inf_nan_frac};
      no_flags = 1'b1;
    end else if (n_is_inf) begin
      res      = {n_sign, FP_INF_EXP, 23'b0};
      no_flags = 1'b1;
    end

    new_flags          = '0;
    new_flags[FLG_OVF] = ovf & ~no_flags;
    new_flags[FLG_UDF] = udf & ~no_flags;
    new_flags[FLG_INX] = inexact & ~no_flags;
    s_d                = res;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s_q       <= '0;
      s_valid_q <= 1'b0;
    end else if (e) begin
      s_q       <= s_d;
      s_valid_q <= n_valid;
    end
  end

  assign s       = s_q;
  assign s_valid = s_valid_q;

`ifdef FMUL_FLAGS_EN
  logic [2:0] flags_d, flags_q;

  always_comb begin
    flags_d = flags_q;
    if (flag_clr)          flags_d = '0;
    else if (e && n_valid) flags_d = flags_q | new_flags;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) flags_q <= '0;
    else       flags_q <= flags_d;
  end

  assign flags = flags_q;
`else
  logic unused_flags;
  assign unused_flags = ^new_flags;
`endif

endmodule

// File: tb/tb_fmul_norm_round.sv
// Directed-vector bench for fmul_norm_round; flag checks are built with FMUL_FLAGS_EN.
module tb_fmul_norm_round;

  logic        clk = 1'b0;
  logic        clrn, e, n_valid, n_sign, n_is_nan, n_is_inf;
  logic [47:0] n_z48;
  logic [22:0] n_inf_nan_frac;
  logic [9:0]  n_exp10;
  logic [1:0]  n_rm;
  logic [31:0] s;
  logic        s_valid;
`ifdef FMUL_FLAGS_EN
  logic [2:0]  flags;
  logic        flag_clr;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  fmul_norm_round dut (
    .clk(clk), .clrn(clrn), .e(e), .n_valid(n_valid), .n_z48(n_z48),
    .n_inf_nan_frac(n_inf_nan_frac), .n_exp10(n_exp10), .n_rm(n_rm),
    .n_sign(n_sign), .n_is_nan(n_is_nan), .n_is_inf(n_is_inf),
`ifdef FMUL_FLAGS_EN
    .flags(flags), .flag_clr(flag_clr),
`endif
    .s(s), .s_valid(s_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  task automatic drive(input logic [47:0] z, input logic [9:0] ex, input logic [1:0] rm,
                       input logic sg, input logic nan, input logic inf,
                       input logic [22:0] frac, input logic vld);
    n_z48 = z; n_exp10 = ex; n_rm = rm; n_sign = sg;
    n_is_nan = nan; n_is_inf = inf; n_inf_nan_frac = frac; n_valid = vld;
  endtask

  // Clear sticky flags while stalled, then issue one operation and check it.
  task automatic op(input string tag, input logic [47:0] z, input logic [9:0] ex,
                    input logic [1:0] rm, input logic sg, input logic nan, input logic inf,
                    input logic [22:0] frac, input logic vld,
                    input logic [31:0] exp_s, input logic [2:0] exp_f);
    @(negedge clk);
    e = 1'b0;
`ifdef FMUL_FLAGS_EN
    flag_clr = 1'b1;
`endif
    @(negedge clk);
`ifdef FMUL_FLAGS_EN
    flag_clr = 1'b0;
`endif
    e = 1'b1;
    drive(z, ex, rm, sg, nan, inf, frac, vld);
    @(posedge clk); #1;
    check(tag, s, exp_s);
    check({tag, "_valid"}, {31'b0, s_valid}, {31'b0, vld});
`ifdef FMUL_FLAGS_EN
    check({tag, "_flags"}, {29'b0, flags}, {29'b0, exp_f});
`else
    if (exp_f === 3'bxxx) $display("unreachable");
`endif
  endtask

  initial begin
    clrn = 1'b0; e = 1'b0;
    drive('0, '0, 2'b00, 1'b0, 1'b0, 1'b0, '0, 1'b0);
`ifdef FMUL_FLAGS_EN
    flag_clr = 1'b0;
`endif
    #12;
    check("rst_s", s, 32'h0);
    check("rst_valid", {31'b0, s_valid}, 32'h0);
`ifdef FMUL_FLAGS_EN
    check("rst_flags", {29'b0, flags}, 32'h0);
`endif
    @(negedge clk); clrn = 1'b1;

    //  tag          z48              exp10   rm     sg    nan   inf   frac       v     s              {O,U,I}
    op("mul1p5",    48'h900000000000, 10'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'h0,     1'b1, 32'h40100000, 3'b000);
    op("tie_rn",    48'h400000400000, 10'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'h0,     1'b1, 32'h3F800000, 3'b001);
    op("tie_rp",    48'h400000400000, 10'd127, 2'b10, 1'b0, 1'b0, 1'b0, 23'h0,     1'b1, 32'h3F800001, 3'b001);
    op("tie_rm_neg",48'h400000400000, 10'd127, 2'b11, 1'b1, 1'b0, 1'b0, 23'h0,     1'b1, 32'hBF800001, 3'b001);
    op("ovf_rn",    48'h400000000000, 10'd300, 2'b00, 1'b0, 1'b0, 1'b0, 23'h0,     1'b1, 32'h7F800000, 3'b101);
    op("ovf_rz",    48'h400000000000, 10'd300, 2'b01, 1'b0, 1'b0, 1'b0, 23'h0,     1'b1, 32'h7F7FFFFF, 3'b101);
    op("denorm",    48'h400000000000, 10'h3F6, 2'b00, 1'b0, 1'b0, 1'b0, 23'h0,     1'b1, 32'h00001000, 3'b000);
    op("rnd_carry", 48'h7FFFFFC00000, 10'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'h0,     1'b1, 32'h40000000, 3'b001);
    op("lshift1",   48'h200000000000, 10'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'h0,     1'b1, 32'h3F000000, 3'b000);
    op("zero_neg",  48'h000000000000, 10'd127, 2'b00, 1'b1, 1'b0, 1'b0, 23'h0,     1'b1, 32'h80000000, 3'b000);
    op("nan",       48'h400000000000, 10'd300, 2'b00, 1'b1, 1'b1, 1'b1, 23'h400000,1'b1, 32'h7FC00000, 3'b000);
    op("inf_neg",   48'h400000000000, 10'd127, 2'b00, 1'b1, 1'b0, 1'b1, 23'h0,     1'b1, 32'hFF800000, 3'b000);
    op("novalid",   48'h900000000000, 10'd127, 2'b00, 1'b0, 1'b0, 1'b0, 23'h0,     1'b0, 32'h40100000, 3'b000);
    op("hold_src",  48'h400000400000, 10'd127, 2'b10, 1'b0, 1'b0, 1'b0, 23'h0,     1'b1, 32'h3F800001, 3'b001);

    // Stall for three cycles with changing inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = 1'b0;
      drive(48'h900000000000 + 48'(i), 10'd100 + 10'(i), 2'(i), 1'b1, 1'b0, 1'b0, '0, i[0]);
      @(posedge clk); #1;
      check("stall_s", s, 32'h3F800001);
      check("stall_valid", {31'b0, s_valid}, 32'h1);
`ifdef FMUL_FLAGS_EN
      check("stall_flags", {29'b0, flags}, 32'h1);
`endif
    end
    #2 clrn = 1'b0;
    #1;
    check("async_rst_s", s, 32'h0);
    check("async_rst_valid", {31'b0, s_valid}, 32'h0);
`ifdef FMUL_FLAGS_EN
    check("async_rst_flags", {29'b0, flags}, 32'h0);
`endif
    @(negedge clk); clrn = 1'b1;

`ifdef FMUL_FLAGS_EN
    @(negedge clk);
    e = 1'b1; flag_clr = 1'b1;
    drive(48'h400000000000, 10'd300, 2'b00, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    @(posedge clk); #1;
    check("clr_vs_set_s", s, 32'h7F800000);
    check("clr_vs_set_flags", {29'b0, flags}, 32'h0);
    @(negedge clk); flag_clr = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
